// File: rtl/ay_pkg.sv
// ay_pkg: bus-function and state encodings, register masks and decode helper for the AY PSG responder
package ay_pkg;
    typedef enum logic [1:0] {INACT, LADDR, WRPSG, RDPSG} bus_fn_t;
    typedef enum logic [1:0] {IDLE, LATCH, WRITE, READ} state_t;
    localparam logic [3:0] R_MIXER = 4'd7;
    localparam logic [3:0] R_ENV_SHAPE = 4'd13;
    // R15 down to R0; R14/R15 are full-width plain storage
    localparam logic [15:0][7:0] REG_MASK = {
        8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF, 8'h1F, 8'h1F, 8'h1F,
        8'hFF, 8'h1F, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF
    };
    function automatic bus_fn_t decode(input logic [2:0] c);
        return c == 3'b110 ? WRPSG :
               c == 3'b011 ? RDPSG :
               (c == 3'b001 || c == 3'b100 || c == 3'b111) ? LADDR : INACT;
    endfunction
endpackage

// File: rtl/ay_bus_sync.sv
// ay_bus_sync: synchronizes the PSG bus pins and DA, then glitch-filters the decoded bus function
module ay_bus_sync
    import ay_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HOLD    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bdir,
    input  logic       bc2,
    input  logic       bc1,
    input  logic [7:0] da_in,
    output logic [1:0] fn_o,
    output logic [1:0] cand_o,
    output logic [7:0] da_sync_o
);
    localparam int CW = $clog2(MIN_HOLD + 1);
    logic [10:0] sync_q [SYNC_STAGES];
    bus_fn_t cand, cand_q, acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_n;
    logic accept;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '{default: '0};
            cand_q <= INACT;
            acc_q  <= INACT;
            cnt_q  <= '0;
        end else begin
            sync_q[0] <= {bdir, bc2, bc1, da_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            cand_q <= cand;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
        end
    end
    // cnt_n counts how many earlier cycles already showed this same candidate
    always_comb begin
        cand   = decode(sync_q[SYNC_STAGES-1][10:8]);
        cnt_n  = cand != cand_q ? '0 : cnt_q + 1'b1;
        accept = cand != acc_q && cnt_n == CW'(MIN_HOLD - 1);
        acc_d  = accept ? cand : acc_q;
        cnt_d  = (cand == acc_q || accept) ? '0 : cnt_n;
    end
    assign fn_o      = acc_d;
    assign cand_o    = cand;
    assign da_sync_o = sync_q[SYNC_STAGES-1][7:0];
endmodule

// File: rtl/ay_psg_bus_responder.sv
// ay_psg_bus_responder: AY-3-8910 bus responder with address latch, masked register file and read-back
module ay_psg_bus_responder
    import ay_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         MIN_HOLD    = 2,
    parameter logic [3:0] CHIP_ADDR   = 4'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bdir,
    input  logic         bc2,
    input  logic         bc1,
    input  logic [7:0]   da_in,
    output logic [7:0]   da_out,
    output logic         da_oe,
    output logic [127:0] regs,
    output logic         wr_stb,
    output logic [3:0]   wr_addr,
    output logic         env_restart
);
    logic [1:0] fn, cand;
    logic [7:0] da_sync;
    state_t state_q, state_d;
    logic [15:0][7:0] regs_q;
    logic [3:0] addr_q, addr_d, wr_addr_q;
    logic addr_valid_q, addr_valid_d, da_oe_q, da_oe_d, wr_stb_q, env_q;
    logic leave_latch, commit;
    logic [7:0] da_hold_q, da_hold_d, da_out_q, da_out_d, wdata;

    ay_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .MIN_HOLD   (MIN_HOLD)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .bdir     (bdir),
        .bc2      (bc2),
        .bc1      (bc1),
        .da_in    (da_in),
        .fn_o     (fn),
        .cand_o   (cand),
        .da_sync_o(da_sync)
    );

    // Exit actions fire on the edge where the accepted state leaves LATCH/WRITE
    always_comb begin
        state_d      = state_t'(fn);
        leave_latch  = state_q == LATCH && state_d != LATCH;
        commit       = state_q == WRITE && state_d != WRITE && addr_valid_q;
        wdata        = da_hold_q & REG_MASK[addr_q];
        addr_d       = leave_latch ? da_hold_q[3:0] : addr_q;
        addr_valid_d = leave_latch ? da_hold_q[7:4] == CHIP_ADDR : addr_valid_q;
        da_hold_d    = ((fn == LADDR || fn == WRPSG) && cand == fn) ? da_sync : da_hold_q;
        da_out_d     = state_d != READ ? 8'h00 : commit ? wdata : regs_q[addr_d];
        da_oe_d      = state_d == READ && addr_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            regs_q       <= '0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            da_hold_q    <= '0;
            da_out_q     <= '0;
            da_oe_q      <= 1'b0;
            wr_stb_q     <= 1'b0;
            wr_addr_q    <= '0;
            env_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
            da_hold_q    <= da_hold_d;
            da_out_q     <= da_out_d;
            da_oe_q      <= da_oe_d;
            wr_stb_q     <= commit;
            env_q        <= commit && addr_q == R_ENV_SHAPE;
            if (commit) begin
                regs_q[addr_q] <= wdata;
                wr_addr_q      <= addr_q;
            end
        end
    end

    assign regs        = regs_q;
    assign da_out      = da_out_q;
    assign da_oe       = da_oe_q;
    assign wr_stb      = wr_stb_q;
    assign wr_addr     = wr_addr_q;
    assign env_restart = env_q;
endmodule

// File: tb/tb_ay_psg_bus_responder.sv
// tb_ay_psg_bus_responder: table-driven write vectors with a write scoreboard plus read, glitch and reset sequences
module tb_ay_psg_bus_responder;
    import ay_pkg::*;
    localparam logic [2:0] P_INACT = 3'b000;
    localparam logic [2:0] P_LATCH = 3'b001;
    localparam logic [2:0] P_WRITE = 3'b110;
    localparam logic [2:0] P_READ  = 3'b011;

    logic clk = 1'b0;
    logic rst, bdir, bc2, bc1, da_oe, wr_stb, env_restart;
    logic [7:0] da_in, da_out;
    logic [127:0] regs;
    logic [3:0] wr_addr;
    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    typedef struct { logic [3:0] addr; logic [7:0] val; logic env; } wr_t;
    typedef struct { logic [7:0] la; logic [7:0] wd; logic stb; logic env; logic [7:0] ev; } vec_t;
    wr_t exp_q[$];
    wr_t e;
    logic [7:0] ref_regs [16];
    vec_t vecs [10];

    always #5 clk = ~clk;

    ay_psg_bus_responder dut (
        .clk        (clk),
        .rst        (rst),
        .bdir       (bdir),
        .bc2        (bc2),
        .bc1        (bc1),
        .da_in      (da_in),
        .da_out     (da_out),
        .da_oe      (da_oe),
        .regs       (regs),
        .wr_stb     (wr_stb),
        .wr_addr    (wr_addr),
        .env_restart(env_restart)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] flat();
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[i*8 +: 8] = ref_regs[i];
        return f;
    endfunction

    task automatic expect_wr(input logic [3:0] a, input logic [7:0] v, input logic en);
        wr_t w;
        w.addr = a;
        w.val  = v;
        w.env  = en;
        exp_q.push_back(w);
        ref_regs[a] = v;
    endtask

    task automatic bus(input logic [2:0] c, input logic [7:0] d, input int n);
        {bdir, bc2, bc1} = c;
        da_in = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (wr_stb) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wr_stb: wr_addr=%0d want no pulse", wr_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", wr_addr, e.addr);
                    chk("env_restart", env_restart, e.env);
                    chk("wr_data", regs[e.addr*8 +: 8], e.val);
                end
            end else if (env_restart) begin
                chk("env_without_stb", env_restart, 0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        {bdir, bc2, bc1} = P_INACT;
        da_in = 8'h00;
        for (int i = 0; i < 16; i++) ref_regs[i] = 8'h00;
        vecs[0] = '{{4'h0, R_MIXER}, 8'hFF, 1'b1, 1'b0, 8'hFF};
        vecs[1] = '{8'h01, 8'hAB, 1'b1, 1'b0, 8'h0B};
        vecs[2] = '{8'h0D, 8'hFE, 1'b1, 1'b1, 8'h0E};
        vecs[3] = '{8'h35, 8'h55, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{8'h06, 8'h1A, 1'b1, 1'b0, 8'h1A};
        vecs[5] = '{8'h08, 8'hFF, 1'b1, 1'b0, 8'h1F};
        vecs[6] = '{8'h0E, 8'hA5, 1'b1, 1'b0, 8'hA5};
        vecs[7] = '{8'h0F, 8'h3C, 1'b1, 1'b0, 8'h3C};
        vecs[8] = '{8'h0A, 8'hE7, 1'b1, 1'b0, 8'h07};
        vecs[9] = '{8'h03, 8'h9C, 1'b1, 1'b0, 8'h0C};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        chk("reset_regs", regs, 0);
        chk("reset_da_out", da_out, 0);
        chk("reset_da_oe", da_oe, 0);
        chk("reset_wr_stb", wr_stb, 0);
        chk("reset_wr_addr", wr_addr, 0);
        chk("reset_env", env_restart, 0);

        for (int i = 0; i < 10; i++) begin
            bus(P_LATCH, vecs[i].la, 6);
            bus(P_INACT, 8'h00, 6);
            bus(P_WRITE, vecs[i].wd, 6);
            if (vecs[i].stb) expect_wr(vecs[i].la[3:0], vecs[i].ev, vecs[i].env);
            bus(P_INACT, 8'h00, 8);
            chk("vec_regs", regs, flat());
            chk("vec_pending", exp_q.size(), 0);
        end

        bus(P_LATCH, 8'h35, 6);
        bus(P_INACT, 8'h00, 6);
        {bdir, bc2, bc1} = P_READ;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            chk("bad_addr_da_oe", da_oe, 0);
        end
        bus(P_INACT, 8'h00, 6);

        bus(P_LATCH, 8'h06, 6);
        {bdir, bc2, bc1} = P_READ;
        da_in = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            chk("rd_da_oe", da_oe, k >= 4);
            chk("rd_da_out", da_out, k >= 4 ? 8'h1A : 8'h00);
        end
        {bdir, bc2, bc1} = P_INACT;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            chk("rd_exit_da_oe", da_oe, k < 4);
            chk("rd_exit_da_out", da_out, k < 4 ? 8'h1A : 8'h00);
        end

        bus(P_LATCH, 8'h09, 6);
        bus(P_INACT, 8'h00, 6);
        bus(P_WRITE, 8'h99, 1);
        bus(P_INACT, 8'h00, 10);
        chk("glitch1_regs", regs, flat());
        expect_wr(4'd9, 8'h19, 1'b0);
        bus(P_WRITE, 8'h99, 2);
        bus(P_INACT, 8'h00, 10);
        chk("glitch2_regs", regs, flat());
        chk("glitch2_pending", exp_q.size(), 0);

        bus(P_LATCH, 8'h0C, 6);
        bus(P_INACT, 8'h00, 6);
        bus(P_WRITE, 8'h77, 6);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) ref_regs[i] = 8'h00;
        chk("midwr_reset_regs", regs, 0);
        bus(P_WRITE, 8'h77, 6);
        bus(P_INACT, 8'h00, 10);
        chk("midwr_regs", regs, flat());

        bus(P_LATCH, 8'h02, 6);
        bus(P_INACT, 8'h00, 6);
        bus(P_WRITE, 8'h12, 6);
        expect_wr(4'd2, 8'h12, 1'b0);
        bus(P_LATCH, 8'h04, 6);
        bus(P_WRITE, 8'h34, 6);
        expect_wr(4'd4, 8'h34, 1'b0);
        bus(P_INACT, 8'h00, 10);
        chk("b2b_regs", regs, flat());
        chk("final_pending", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ay_psg_bus_responder.md
# ay_psg_bus_responder

Chip-side responder for the AY-3-8910 PSG bus protocol driven by the BK sound-interface logic. Samples asynchronous BDIR/BC2/BC1 and the DA[7:0] bus, filters glitches, and decodes the four bus functions: inactive, latch address, write PSG and read PSG. Performs register-address latch, masked writes into the 16 × 8 PSG register file and read-back onto DA. Feeds the tone, noise and envelope generators with register contents and an envelope-restart pulse.

## Interface
- SYNC_STAGES, 2: synchronizer depth applied to bdir, bc2, bc1 and da_in (all delayed equally).
- MIN_HOLD, 2: consecutive synchronized cycles a decoded bus function must be stable before acceptance (≥1).
- CHIP_ADDR, 4'h0: required value of DA[7:4] during address latch.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- bdir, bc2, bc1  in  1 each  PSG bus control, asynchronous to clk.
- da_in  in  8  DA bus as driven by the CPU side, asynchronous.
- da_out  out  8  read data toward DA.
- da_oe  out  1  DA drive enable (read PSG accepted and address valid).
- regs  out  128  register file, R0 in [7:0] … R15 in [127:120].
- wr_stb  out  1  one-cycle pulse per committed write.
- wr_addr  out  4  register index of the last committed write.
- env_restart  out  1  one-cycle pulse coincident with wr_stb when wr_addr = 13.

## Operation
- Decode of synchronized {bdir,bc2,bc1}: 000, 010, 101 → INACT; 001, 100, 111 → LADDR; 110 → WRPSG; 011 → RDPSG.
- Accepted-state FSM: IDLE, LATCH, WRITE, READ. The candidate is the decoded function. When candidate ≠ accepted, a hold counter increments; the counter clears whenever the candidate changes or equals accepted. Acceptance occurs when the count reaches MIN_HOLD−1. Shorter pulses are ignored entirely.
- Data hold: while accepted ∈ {LATCH, WRITE} and candidate = accepted, da_hold ← synchronized da_in every cycle.
- Leaving LATCH (any next state): addr ← da_hold[3:0]; addr_valid ← (da_hold[7:4] = CHIP_ADDR).
- Leaving WRITE: if addr_valid, regs[addr] ← da_hold & MASK[addr], wr_stb = 1, wr_addr ← addr. If !addr_valid, the write is dropped with no pulse.
- Direct transitions, such as WRITE→LATCH with no intervening INACT, commit the exit action, then enter the new state. A write followed by re-latch behaves the same as with an idle gap.
- READ: da_oe = 1 while accepted = READ and addr_valid. da_out is registered as regs[addr] (already masked). Outside READ, da_out holds 8'h00.
- Masks: R1, R3, R5, R13 → 8'h0F; R6, R8, R9, R10 → 8'h1F; all others → 8'hFF. R14/R15 are plain storage.
- addr persists across any number of writes and reads until the next LATCH exit.

## Timing
- Reset (one rising clk with rst = 1) sets regs = 0, addr = 0, addr_valid = 0, da_hold = 0, state IDLE, counter 0, da_out = 0, da_oe = 0, wr_stb = 0, wr_addr = 0, env_restart = 0. Synchronizer flops also clear.
- Reset mid-write discards the pending write: no pulse is generated and the register is unchanged.
- Acceptance latency is SYNC_STAGES + MIN_HOLD clk edges from the pin change; with defaults this is 4.
- Write commit and the wr_stb pulse occur 1 cycle after the accepted state leaves WRITE.
- da_oe asserts in the same cycle that READ is accepted, and deasserts the cycle after READ is exited.
- Simultaneous LATCH exit and READ entry: READ uses the newly latched addr from its first cycle, so the address mux reads the next-state addr.

## Structure
- Package ay_pkg holds:
  - bus-function encoding (INACT/LADDR/WRPSG/RDPSG);
  - FSM state type;
  - the 16-entry mask constant;
  - register index constants (R_ENV_SHAPE = 13, R_MIXER = 7).
- Sub-module ay_bus_sync: synchronizer chains plus the hold-counter glitch filter. It outputs the accepted function and da_sync.
- The top level owns the FSM actions, the register file and the read mux.

## Test plan
- Reset, then LATCH da=8'h07, INACT, WRITE da=8'hFF, INACT → regs[63:56]=8'hFF, one wr_stb, wr_addr=7, env_restart=0.
- LATCH 8'h01, WRITE 8'hAB → R1=8'h0B. LATCH 8'h0D, WRITE 8'hFE → R13=8'h0E with env_restart pulsing once alongside wr_stb.
- LATCH 8'h35 (CHIP_ADDR=0), WRITE 8'h55 → no wr_stb and regs unchanged. Then RDPSG → da_oe stays 0.
- Write R6=8'h1A, LATCH 8'h06, RDPSG for 10 cycles → da_oe=1 and da_out=8'h1A after the 4-cycle latency. Both return to 0 one cycle after INACT.
- A one-cycle 110 glitch inside INACT, with da=8'h99 → no state change and no write. Repeat with a 2-cycle glitch → write accepted.
- rst asserted during an accepted WRITE → after release, the target register is 0 and wr_stb never pulsed. Back-to-back WRITE→LATCH→WRITE without INACT → both writes committed to the correct registers.
